tx_ltssm_sequencer: RTL and testbench

Parametrised transmit-side LTSSM sequencer for the PCIe link-training path. It follows the main LTSSM's state command and drives the PIPE TX control (detect and electrical idle), the ordered-set generator handshake, and the LPIF data hold/mux. It reports completion of each state back to the main LTSSM. Compared with the fixed x16 TX block, it adds:
- lane count, OS-count thresholds and timeouts as parameters,
- partial-width detect,
- Polling timeout,
- a Recovery path back to L0.

---
 rtl/tx_ltssm_sequencer_pkg.sv | 45 ++++
 rtl/tx_ltssm_sequencer_if.sv | 32 +++
 rtl/tx_ltssm_sequencer_timeout_counter.sv | 35 +++
 rtl/tx_ltssm_sequencer.sv | 296 +++++++++++++++++++++++++++++
 tb/tb_tx_ltssm_sequencer.sv | 406 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/tx_ltssm_sequencer_pkg.sv
// Shared types for the TX LTSSM sequencer: state codes, OS types, device types.
// TX_LTSSM_RECOVERY_EN enables decode of the Recovery states B/C/D.
package tx_ltssm_pkg;

    typedef enum logic [3:0] {
        DetectQuiet        = 4'h0,
        DetectActive       = 4'h1,
        PollingActive      = 4'h2,
        PollingConfig      = 4'h3,
        CfgLinkWidthStart  = 4'h4,
        CfgLinkWidthAccept = 4'h5,
        CfgLaneNumWait     = 4'h6,
        CfgLaneNumActive   = 4'h7,
        CfgComplete        = 4'h8,
        CfgIdle            = 4'h9,
        L0                 = 4'hA,
        RecoveryRcvrLock   = 4'hB,
        RecoveryRcvrCfg    = 4'hC,
        RecoveryIdle       = 4'hD,
        Idle               = 4'hF
    } ltssmState_e;

    typedef enum logic [2:0] {
        OsTs1  = 3'd0,
        OsTs2  = 3'd1,
        OsIdle = 3'd4
    } osType_e;

    localparam int devDownstream = 0;
    localparam int devUpstream   = 1;

    localparam logic [7:0] linkPad = 8'd0;

    // Codes without a behaviour in this build fall back to Idle.
    function automatic ltssmState_e decodeState(input logic [3:0] code);
        ltssmState_e s;
        s = Idle;
        if (code <= 4'hA) s = ltssmState_e'(code);
`ifdef TX_LTSSM_RECOVERY_EN
        else if (code <= 4'hD) s = ltssmState_e'(code);
`endif
        return s;
    endfunction

endpackage

// File: rtl/tx_ltssm_sequencer_if.sv
// Ordered-set generator handshake and OS field bundle.
interface tx_ltssm_sequencer_if;

    logic [2:0] OSType;
    logic [7:0] LinkNumber;
    logic [4:0] LaneNumber;
    logic [2:0] Rate;
    logic       OSGeneratorStart;
    logic       OSGeneratorBusy;
    logic       OSGeneratorFinish;

    modport master (
        output OSType,
        output LinkNumber,
        output LaneNumber,
        output Rate,
        output OSGeneratorStart,
        input  OSGeneratorBusy,
        input  OSGeneratorFinish
    );

    modport slave (
        input  OSType,
        input  LinkNumber,
        input  LaneNumber,
        input  Rate,
        input  OSGeneratorStart,
        output OSGeneratorBusy,
        output OSGeneratorFinish
    );

endinterface

// File: rtl/tx_ltssm_sequencer_timeout_counter.sv
// Per-state timeout counter with 12 ms / 24 ms compare flags.
module ltssm_timeout_counter #(
    parameter int T12MS = 1500000,
    parameter int T24MS = 3000000,
    parameter int W     = 32
) (
    input  logic         Pclk,
    input  logic         Reset,
    input  logic         clear,
    input  logic         load,
    input  logic [W-1:0] loadVal,
    input  logic         enable,
    output logic         hit12,
    output logic         hit24
);

    logic [W-1:0] count;

    // Saturates so the compare flags stay high after expiry.
    always_ff @(posedge Pclk) begin
        if (!Reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (load) begin
            count <= loadVal;
        end else if (enable && (count != '1)) begin
            count <= count + W'(1);
        end
    end

    assign hit12 = (count >= W'(T12MS));
    assign hit24 = (count >= W'(T24MS));

endmodule

// File: rtl/tx_ltssm_sequencer.sv
// Transmit-side LTSSM sequencer: PIPE TX control, OS generator handshake, LPIF mux.
// TX_LTSSM_RECOVERY_EN enables RecoveryRcvrLock/RcvrCfg/Idle.
module tx_ltssm_sequencer
    import tx_ltssm_pkg::*;
#(
    parameter int LANES        = 16,
    parameter int DEVICE_TYPE  = 0,
    parameter int MAX_GEN      = 1,
    parameter int POLL_ACT_OS  = 1024,
    parameter int POLL_CFG_OS  = 16,
    parameter int CFG_OS       = 16,
    parameter int RCVR_LOCK_OS = 16,
    parameter int T12MS        = 1500000,
    parameter int T24MS        = 3000000
) (
    input  logic                       Pclk,
    input  logic                       Reset,
    input  logic [3:0]                 SetTXState,
    output logic                       TXFinishFlag,
    output logic [3:0]                 TXExitTo,
    input  logic [LANES-1:0]           DetectStatus,
    output logic [LANES-1:0]           DetectReq,
    output logic [LANES-1:0]           ElecIdleReq,
    output logic [LANES-1:0]           DetectLanes,
    output logic [$clog2(LANES+1)-1:0] NumberDetectLanes,
    output logic                       WriteDetectLanesFlag,
    input  logic [7:0]                 ReadLinkNum,
    output logic [7:0]                 WriteLinkNum,
    output logic                       WriteLinkNumFlag,
    tx_ltssm_sequencer_if.master       osIf,
    output logic                       HoldFIFOData,
    output logic                       MuxSel,
    output logic                       turnOff
);

    localparam int NW = $clog2(LANES + 1);

    ltssmState_e state;
    ltssmState_e nextState;
    ltssmState_e exitTo;
    logic        stateChg;
    logic        exitCond;
    logic        fire;
    logic        done;
    logic        hit12;
    logic        hit24;
    logic        allDet;
    logic        anyDet;
    logic [NW-1:0] numDet;
    logic [15:0] osCnt;
    logic        outstanding;
    logic        startD;
    logic        linkDone;
    logic        linkWrD;
    logic        detWrD;

    logic             osState;
    osType_e          osTypeD;
    logic [7:0]       linkD;
    logic [4:0]       laneD;
    logic [LANES-1:0] detReqD;
    logic [LANES-1:0] eidleD;
    logic             holdD;
    logic             muxD;
    logic             turnOffD;

    ltssm_timeout_counter #(
        .T12MS (T12MS),
        .T24MS (T24MS),
        .W     (32)
    ) uTimeout (
        .Pclk    (Pclk),
        .Reset   (Reset),
        .clear   (stateChg),
        .load    (1'b0),
        .loadVal (32'd0),
        .enable  (1'b1),
        .hit12   (hit12),
        .hit24   (hit24)
    );

    assign allDet = &DetectStatus;
    assign anyDet = |DetectStatus;

    always_comb begin
        numDet = '0;
        for (int i = 0; i < LANES; i++) begin
            if (DetectStatus[i]) numDet = NW'(i + 1);
        end
    end

    always_ff @(posedge Pclk) begin
        if (!Reset) state <= Idle;
        else        state <= nextState;
    end

    always_comb begin
        nextState = decodeState(SetTXState);
        stateChg  = (nextState != state);
        exitCond  = 1'b0;
        exitTo    = DetectQuiet;
        unique case (state)
            DetectQuiet: begin
                exitCond = hit12;
                exitTo   = DetectActive;
            end
            DetectActive: begin
                exitCond = allDet || hit12;
                exitTo   = anyDet ? PollingActive : DetectQuiet;
            end
            PollingActive: begin
                if (osCnt >= 16'(POLL_ACT_OS)) begin
                    exitCond = 1'b1;
                    exitTo   = PollingConfig;
                end else if (hit24) begin
                    exitCond = 1'b1;
                    exitTo   = DetectQuiet;
                end
            end
            PollingConfig: begin
                exitCond = (osCnt >= 16'(POLL_CFG_OS));
                exitTo   = CfgLinkWidthStart;
            end
            CfgLinkWidthAccept: begin
                exitCond = (DEVICE_TYPE == devDownstream) && osIf.OSGeneratorFinish;
                exitTo   = CfgLaneNumWait;
            end
            CfgComplete: begin
                exitCond = (osCnt >= 16'(CFG_OS));
                exitTo   = CfgIdle;
            end
            CfgIdle: begin
                exitCond = (osCnt >= 16'(CFG_OS));
                exitTo   = L0;
            end
`ifdef TX_LTSSM_RECOVERY_EN
            RecoveryRcvrLock: begin
                if (osCnt >= 16'(RCVR_LOCK_OS)) begin
                    exitCond = 1'b1;
                    exitTo   = RecoveryRcvrCfg;
                end else if (hit24) begin
                    exitCond = 1'b1;
                    exitTo   = DetectQuiet;
                end
            end
            RecoveryRcvrCfg: begin
                exitCond = (osCnt >= 16'(CFG_OS));
                exitTo   = RecoveryIdle;
            end
            RecoveryIdle: begin
                exitCond = (osCnt >= 16'(CFG_OS));
                exitTo   = L0;
            end
`endif
            default: ;
        endcase
    end

    always_comb begin
        osState  = 1'b0;
        osTypeD  = OsTs1;
        linkD    = '0;
        laneD    = '0;
        detReqD  = '0;
        eidleD   = '0;
        holdD    = 1'b1;
        muxD     = 1'b0;
        turnOffD = 1'b1;
        unique case (state)
            DetectQuiet:   eidleD = '1;
            DetectActive:  detReqD = '1;
            PollingActive: osState = 1'b1;
            PollingConfig: begin
                osState = 1'b1;
                osTypeD = OsTs2;
            end
            CfgLinkWidthStart: begin
                osState = 1'b1;
                linkD   = (DEVICE_TYPE == devDownstream) ? 8'd1 : linkPad;
            end
            CfgLinkWidthAccept, CfgLaneNumWait, CfgLaneNumActive: begin
                osState = 1'b1;
                linkD   = ReadLinkNum;
                laneD   = 5'd1;
            end
            CfgComplete: begin
                osState = 1'b1;
                osTypeD = OsTs2;
                linkD   = ReadLinkNum;
                laneD   = 5'd1;
            end
            CfgIdle: begin
                osState = 1'b1;
                osTypeD = OsIdle;
            end
            L0: begin
                holdD    = 1'b0;
                muxD     = 1'b1;
                turnOffD = 1'b0;
            end
`ifdef TX_LTSSM_RECOVERY_EN
            RecoveryRcvrLock: begin
                osState = 1'b1;
                linkD   = ReadLinkNum;
                laneD   = 5'd1;
            end
            RecoveryRcvrCfg: begin
                osState = 1'b1;
                osTypeD = OsTs2;
                linkD   = ReadLinkNum;
                laneD   = 5'd1;
            end
            RecoveryIdle: begin
                osState = 1'b1;
                osTypeD = OsIdle;
            end
`endif
            default: ;
        endcase
    end

    assign fire   = exitCond && !done;
    assign detWrD = fire && (state == DetectActive) && (exitTo == PollingActive);
    assign linkWrD = (state == CfgLinkWidthStart) && (DEVICE_TYPE == devDownstream)
                     && !linkDone && !stateChg;
    // No new OS once the state has met its exit, so the count never overshoots.
    assign startD = osState && !osIf.OSGeneratorBusy && !outstanding
                    && !done && !exitCond && !stateChg;

    always_ff @(posedge Pclk) begin
        if (!Reset) begin
            TXFinishFlag         <= 1'b0;
            TXExitTo             <= 4'h0;
            done                 <= 1'b0;
            osCnt                <= '0;
            outstanding          <= 1'b0;
            osIf.OSGeneratorStart <= 1'b0;
            DetectLanes          <= '0;
            NumberDetectLanes    <= '0;
            WriteDetectLanesFlag <= 1'b0;
            linkDone             <= 1'b0;
            WriteLinkNum         <= 8'd0;
            WriteLinkNumFlag     <= 1'b0;
        end else begin
            TXFinishFlag <= fire;
            if (fire) TXExitTo <= exitTo;
            done <= stateChg ? 1'b0 : (done | fire);

            if (stateChg)
                osCnt <= '0;
            else if (osIf.OSGeneratorFinish && (osCnt != '1))
                osCnt <= osCnt + 16'd1;

            osIf.OSGeneratorStart <= startD;
            if (startD)
                outstanding <= 1'b1;
            else if (osIf.OSGeneratorFinish)
                outstanding <= 1'b0;

            WriteDetectLanesFlag <= detWrD;
            if (detWrD) begin
                DetectLanes       <= DetectStatus;
                NumberDetectLanes <= numDet;
            end

            linkDone         <= stateChg ? 1'b0 : (linkDone | linkWrD);
            WriteLinkNumFlag <= linkWrD;
            if (linkWrD) WriteLinkNum <= 8'd1;
        end
    end

    always_ff @(posedge Pclk) begin
        if (!Reset) begin
            DetectReq       <= '0;
            ElecIdleReq     <= '0;
            osIf.OSType     <= 3'd0;
            osIf.LinkNumber <= 8'd0;
            osIf.LaneNumber <= 5'd0;
            osIf.Rate       <= 3'(MAX_GEN);
            HoldFIFOData    <= 1'b1;
            MuxSel          <= 1'b0;
            turnOff         <= 1'b1;
        end else begin
            DetectReq       <= detReqD;
            ElecIdleReq     <= eidleD;
            osIf.OSType     <= osTypeD;
            osIf.LinkNumber <= linkD;
            osIf.LaneNumber <= laneD;
            osIf.Rate       <= 3'(MAX_GEN);
            HoldFIFOData    <= holdD;
            MuxSel          <= muxD;
            turnOff         <= turnOffD;
        end
    end

endmodule

// File: tb/tb_tx_ltssm_sequencer.sv
// Directed bench for tx_ltssm_sequencer (LANES=4, shortened timers and OS counts).
module tb_tx_ltssm_sequencer;

    logic       Pclk = 1'b0;
    logic       Reset;
    logic [3:0] SetTXState;
    logic       TXFinishFlag;
    logic [3:0] TXExitTo;
    logic [3:0] DetectStatus;
    logic [3:0] DetectReq;
    logic [3:0] ElecIdleReq;
    logic [3:0] DetectLanes;
    logic [2:0] NumberDetectLanes;
    logic       WriteDetectLanesFlag;
    logic [7:0] ReadLinkNum;
    logic [7:0] WriteLinkNum;
    logic       WriteLinkNumFlag;
    logic       HoldFIFOData;
    logic       MuxSel;
    logic       turnOff;

    tx_ltssm_sequencer_if ifc ();

    tx_ltssm_sequencer #(
        .LANES        (4),
        .DEVICE_TYPE  (0),
        .MAX_GEN      (1),
        .POLL_ACT_OS  (8),
        .POLL_CFG_OS  (4),
        .CFG_OS       (4),
        .RCVR_LOCK_OS (4),
        .T12MS        (20),
        .T24MS        (50)
    ) dut (
        .Pclk                 (Pclk),
        .Reset                (Reset),
        .SetTXState           (SetTXState),
        .TXFinishFlag         (TXFinishFlag),
        .TXExitTo             (TXExitTo),
        .DetectStatus         (DetectStatus),
        .DetectReq            (DetectReq),
        .ElecIdleReq          (ElecIdleReq),
        .DetectLanes          (DetectLanes),
        .NumberDetectLanes    (NumberDetectLanes),
        .WriteDetectLanesFlag (WriteDetectLanesFlag),
        .ReadLinkNum          (ReadLinkNum),
        .WriteLinkNum         (WriteLinkNum),
        .WriteLinkNumFlag     (WriteLinkNumFlag),
        .osIf                 (ifc.master),
        .HoldFIFOData         (HoldFIFOData),
        .MuxSel               (MuxSel),
        .turnOff              (turnOff)
    );

    always #5 Pclk = ~Pclk;

    int total = 0;
    int bad = 0;

    int         nFlag;
    int         firstAt;
    int         nStart;
    int         nWdl;
    int         nWln;
    logic [3:0] exitTo;
    logic [2:0] lastType;
    logic [7:0] lastLink;
    logic [4:0] lastLane;

    task automatic do_reset();
        Reset = 1'b0;
        SetTXState = 4'hF;
        DetectStatus = 4'b0000;
        ReadLinkNum = 8'h5A;
        ifc.OSGeneratorBusy = 1'b0;
        ifc.OSGeneratorFinish = 1'b0;
        repeat (3) @(posedge Pclk);
        #1;
        Reset = 1'b1;
    endtask

    // Runs n edges; edge 1 is the one that loads SetTXState. Optional OS generator
    // model: Busy for 2 cycles after each Start, then a one-cycle Finish.
    task automatic run(input int n, input bit gen);
        int bl;
        bl = 0;
        nFlag = 0; firstAt = 0; nStart = 0; nWdl = 0; nWln = 0;
        exitTo = '0; lastType = '0; lastLink = '0; lastLane = '0;
        ifc.OSGeneratorBusy = 1'b0;
        ifc.OSGeneratorFinish = 1'b0;
        for (int i = 1; i <= n; i++) begin
            @(posedge Pclk);
            #1;
            if (TXFinishFlag) begin
                nFlag++;
                if (nFlag == 1) begin
                    firstAt = i;
                    exitTo = TXExitTo;
                end
            end
            if (WriteDetectLanesFlag) nWdl++;
            if (WriteLinkNumFlag) nWln++;
            if (ifc.OSGeneratorStart) begin
                nStart++;
                lastType = ifc.OSType;
                lastLink = ifc.LinkNumber;
                lastLane = ifc.LaneNumber;
            end
            ifc.OSGeneratorFinish = 1'b0;
            if (gen) begin
                if (ifc.OSGeneratorStart) begin
                    ifc.OSGeneratorBusy = 1'b1;
                    bl = 2;
                end else if (bl > 0) begin
                    bl--;
                    if (bl == 0) begin
                        ifc.OSGeneratorBusy = 1'b0;
                        ifc.OSGeneratorFinish = 1'b1;
                    end
                end
            end
        end
        ifc.OSGeneratorBusy = 1'b0;
        ifc.OSGeneratorFinish = 1'b0;
    endtask

    task automatic test_reset();
        Reset = 1'b0;
        SetTXState = 4'h2;
        DetectStatus = 4'b1111;
        ReadLinkNum = 8'h5A;
        ifc.OSGeneratorBusy = 1'b0;
        ifc.OSGeneratorFinish = 1'b0;
        repeat (3) @(posedge Pclk);
        #1;
        total++;
        if ({TXFinishFlag, TXExitTo, DetectReq, ElecIdleReq, DetectLanes} !== 17'h0) begin
            bad++;
            $display("FAIL rst_ctl got=%h want=0",
                     {TXFinishFlag, TXExitTo, DetectReq, ElecIdleReq, DetectLanes});
        end
        total++;
        if ({WriteDetectLanesFlag, WriteLinkNumFlag, ifc.OSGeneratorStart} !== 3'b000) begin
            bad++;
            $display("FAIL rst_pulse got=%b want=000",
                     {WriteDetectLanesFlag, WriteLinkNumFlag, ifc.OSGeneratorStart});
        end
        total++;
        if ({ifc.OSType, ifc.LinkNumber, ifc.LaneNumber, ifc.Rate} !== {3'd0, 8'd0, 5'd0, 3'd1}) begin
            bad++;
            $display("FAIL rst_os got=%h want=%h",
                     {ifc.OSType, ifc.LinkNumber, ifc.LaneNumber, ifc.Rate},
                     {3'd0, 8'd0, 5'd0, 3'd1});
        end
        total++;
        if ({HoldFIFOData, MuxSel, turnOff} !== 3'b101) begin
            bad++;
            $display("FAIL rst_dp got=%b want=101", {HoldFIFOData, MuxSel, turnOff});
        end
        total++;
        if (dut.state !== 4'hF) begin
            bad++;
            $display("FAIL rst_state got=%h want=f", dut.state);
        end
        SetTXState = 4'hF;
        DetectStatus = 4'b0000;
        Reset = 1'b1;
        run(3, 1'b0);
        total++;
        if (nFlag !== 0) begin
            bad++;
            $display("FAIL rst_noflag got=%0d want=0", nFlag);
        end
    endtask

    task automatic test_detect_all();
        do_reset();
        DetectStatus = 4'b1111;
        SetTXState = 4'h1;
        run(30, 1'b0);
        total++;
        if (nFlag !== 1 || firstAt !== 2) begin
            bad++;
            $display("FAIL da_all_flag got=%0d@%0d want=1@2", nFlag, firstAt);
        end
        total++;
        if (exitTo !== 4'h2) begin
            bad++;
            $display("FAIL da_all_exit got=%h want=2", exitTo);
        end
        total++;
        if (DetectLanes !== 4'b1111 || NumberDetectLanes !== 3'd4) begin
            bad++;
            $display("FAIL da_all_lanes got=%b/%0d want=1111/4", DetectLanes, NumberDetectLanes);
        end
        total++;
        if (nWdl !== 1 || DetectReq !== 4'b1111) begin
            bad++;
            $display("FAIL da_all_wdl got=%0d/%b want=1/1111", nWdl, DetectReq);
        end
    endtask

    task automatic test_detect_partial();
        do_reset();
        DetectStatus = 4'b0011;
        SetTXState = 4'h1;
        run(30, 1'b0);
        total++;
        if (nFlag !== 1 || firstAt !== 22 || exitTo !== 4'h2) begin
            bad++;
            $display("FAIL da_part got=%0d@%0d->%h want=1@22->2", nFlag, firstAt, exitTo);
        end
        total++;
        if (DetectLanes !== 4'b0011 || NumberDetectLanes !== 3'd2 || nWdl !== 1) begin
            bad++;
            $display("FAIL da_part_lanes got=%b/%0d/%0d want=0011/2/1",
                     DetectLanes, NumberDetectLanes, nWdl);
        end
    endtask

    task automatic test_detect_none();
        do_reset();
        DetectStatus = 4'b0000;
        SetTXState = 4'h1;
        run(30, 1'b0);
        total++;
        if (nFlag !== 1 || firstAt !== 22 || exitTo !== 4'h0 || nWdl !== 0) begin
            bad++;
            $display("FAIL da_none got=%0d@%0d->%h wdl=%0d want=1@22->0 wdl=0",
                     nFlag, firstAt, exitTo, nWdl);
        end
    endtask

    task automatic test_quiet();
        do_reset();
        SetTXState = 4'h0;
        run(30, 1'b0);
        total++;
        if (nFlag !== 1 || firstAt !== 22 || exitTo !== 4'h1) begin
            bad++;
            $display("FAIL dq got=%0d@%0d->%h want=1@22->1", nFlag, firstAt, exitTo);
        end
        total++;
        if (ElecIdleReq !== 4'b1111 || DetectReq !== 4'b0000) begin
            bad++;
            $display("FAIL dq_pipe got=%b/%b want=1111/0000", ElecIdleReq, DetectReq);
        end
    endtask

    task automatic test_poll_os();
        do_reset();
        SetTXState = 4'h2;
        run(60, 1'b1);
        total++;
        if (nStart !== 8) begin
            bad++;
            $display("FAIL pa_starts got=%0d want=8", nStart);
        end
        total++;
        if (nFlag !== 1 || firstAt !== 34 || exitTo !== 4'h3) begin
            bad++;
            $display("FAIL pa_exit got=%0d@%0d->%h want=1@34->3", nFlag, firstAt, exitTo);
        end
        total++;
        if (lastType !== 3'd0 || lastLink !== 8'd0 || lastLane !== 5'd0 || ifc.Rate !== 3'd1) begin
            bad++;
            $display("FAIL pa_os got=%0d/%h/%0d/%0d want=0/00/0/1",
                     lastType, lastLink, lastLane, ifc.Rate);
        end
    endtask

    task automatic test_poll_timeout();
        do_reset();
        SetTXState = 4'h2;
        run(60, 1'b0);
        total++;
        if (nFlag !== 1 || firstAt !== 52 || exitTo !== 4'h0) begin
            bad++;
            $display("FAIL pa_tmo got=%0d@%0d->%h want=1@52->0", nFlag, firstAt, exitTo);
        end
    endtask

    task automatic test_cfg_start();
        do_reset();
        SetTXState = 4'h4;
        run(8, 1'b0);
        total++;
        if (nWln !== 1 || WriteLinkNum !== 8'd1) begin
            bad++;
            $display("FAIL lws_wr got=%0d/%h want=1/01", nWln, WriteLinkNum);
        end
        total++;
        if (nStart !== 1 || lastLink !== 8'd1 || lastType !== 3'd0 || nFlag !== 0) begin
            bad++;
            $display("FAIL lws_os got=%0d/%h/%0d/%0d want=1/01/0/0",
                     nStart, lastLink, lastType, nFlag);
        end
    endtask

    task automatic test_cfg_accept();
        do_reset();
        SetTXState = 4'h5;
        run(12, 1'b1);
        total++;
        if (nFlag !== 1 || firstAt !== 5 || exitTo !== 4'h6) begin
            bad++;
            $display("FAIL lwa got=%0d@%0d->%h want=1@5->6", nFlag, firstAt, exitTo);
        end
        total++;
        if (nStart !== 1 || lastLink !== 8'h5A || lastLane !== 5'd1) begin
            bad++;
            $display("FAIL lwa_os got=%0d/%h/%0d want=1/5a/1", nStart, lastLink, lastLane);
        end
    endtask

    task automatic test_cfg_complete();
        do_reset();
        SetTXState = 4'h8;
        run(30, 1'b1);
        total++;
        if (nFlag !== 1 || firstAt !== 18 || exitTo !== 4'h9 || nStart !== 4) begin
            bad++;
            $display("FAIL cc got=%0d@%0d->%h s=%0d want=1@18->9 s=4",
                     nFlag, firstAt, exitTo, nStart);
        end
        total++;
        if (lastType !== 3'd1 || lastLink !== 8'h5A || lastLane !== 5'd1) begin
            bad++;
            $display("FAIL cc_os got=%0d/%h/%0d want=1/5a/1", lastType, lastLink, lastLane);
        end
        SetTXState = 4'h9;
        run(30, 1'b1);
        total++;
        if (nFlag !== 1 || exitTo !== 4'hA || nStart !== 4 || lastType !== 3'd4) begin
            bad++;
            $display("FAIL ci got=%0d->%h s=%0d t=%0d want=1->a s=4 t=4",
                     nFlag, exitTo, nStart, lastType);
        end
    endtask

    task automatic test_l0();
        SetTXState = 4'hA;
        run(3, 1'b0);
        total++;
        if ({HoldFIFOData, MuxSel, turnOff} !== 3'b010 || nStart !== 0 || nFlag !== 0) begin
            bad++;
            $display("FAIL l0 got=%b s=%0d f=%0d want=010 s=0 f=0",
                     {HoldFIFOData, MuxSel, turnOff}, nStart, nFlag);
        end
    endtask

    task automatic test_recovery();
        do_reset();
        SetTXState = 4'hB;
`ifdef TX_LTSSM_RECOVERY_EN
        run(30, 1'b1);
        total++;
        if (nFlag !== 1 || exitTo !== 4'hC || nStart !== 4 || lastType !== 3'd0) begin
            bad++;
            $display("FAIL rlock got=%0d->%h s=%0d t=%0d want=1->c s=4 t=0",
                     nFlag, exitTo, nStart, lastType);
        end
        SetTXState = 4'hC;
        run(30, 1'b1);
        total++;
        if (nFlag !== 1 || exitTo !== 4'hD || nStart !== 4 || lastType !== 3'd1) begin
            bad++;
            $display("FAIL rcfg got=%0d->%h s=%0d t=%0d want=1->d s=4 t=1",
                     nFlag, exitTo, nStart, lastType);
        end
        SetTXState = 4'hD;
        run(30, 1'b1);
        total++;
        if (nFlag !== 1 || firstAt !== 18 || exitTo !== 4'hA || lastType !== 3'd4) begin
            bad++;
            $display("FAIL ridle got=%0d@%0d->%h t=%0d want=1@18->a t=4",
                     nFlag, firstAt, exitTo, lastType);
        end
`else
        run(20, 1'b1);
        total++;
        if (nStart !== 0 || nFlag !== 0 || HoldFIFOData !== 1'b1) begin
            bad++;
            $display("FAIL rec_off got=s%0d f%0d h%b want=s0 f0 h1", nStart, nFlag, HoldFIFOData);
        end
`endif
    endtask

    initial begin
        test_reset();
        test_detect_all();
        test_detect_partial();
        test_detect_none();
        test_quiet();
        test_poll_os();
        test_poll_timeout();
        test_cfg_start();
        test_cfg_accept();
        test_cfg_complete();
        test_l0();
        test_recovery();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
